// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: default sizes and the round-robin pick helper.
// Used by every crossbar output arbiter.
package crossbar_pkg;
    localparam int DEF_NUM_IN    = 6;
    localparam int DEF_DATA_SIZE = 32;
    localparam int MAX_IN        = 32;
    localparam int MAX_IDX_W     = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... with wrap at n-1; first set request wins.
    function automatic pick_t rr_pick(
        input logic [MAX_IN-1:0]    req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   n
    );
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_IN; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !p.found && req[j[MAX_IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[MAX_IDX_W-1:0];
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the rotating priority pointer.
// The pointer moves past the winner only when the grant is consumed.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);
    logic [IDX_W-1:0] r_ptr;
    pick_t            w_pick;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_pick  = rr_pick(MAX_IN'(req), MAX_IDX_W'(r_ptr), NUM_IN);
        w_idx   = w_pick.idx[IDX_W-1:0];
        gnt     = '0;
        if (w_pick.found) gnt[w_idx] = 1'b1;
        gnt_idx = w_idx;
    end

    // Explicit wrap keeps the pointer legal for non-power-of-two NUM_IN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_pick.found) begin
            if (w_idx == IDX_W'(NUM_IN - 1)) r_ptr <= '0;
            else r_ptr <= w_idx + IDX_W'(1);
        end
    end

    a_ptr_range: assert property (
        @(posedge clk) disable iff (rst) int'(r_ptr) < NUM_IN
    );
endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 mux with a full-throughput single-entry output register.
// One instance per crossbar destination port.
module rr_arb_mux
    import crossbar_pkg::*;
#(
    parameter  int NUM_IN    = DEF_NUM_IN,
    parameter  int DATA_SIZE = DEF_DATA_SIZE,
    localparam int IDX_W     = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [IDX_W-1:0]            out_src,
    input  logic                        out_ready
);
    logic                 r_valid;
    logic [DATA_SIZE-1:0] r_data;
    logic [IDX_W-1:0]     r_src;
    logic                 w_load;
    logic                 w_any;
    logic                 w_fire;
    logic [NUM_IN-1:0]    w_gnt;
    logic [IDX_W-1:0]     w_idx;
    logic [DATA_SIZE-1:0] w_data;

    // Reset blocks new grants so nothing is handed over while clearing.
    assign w_load   = !rst && (!r_valid || out_ready);
    assign w_any    = |in_valid;
    assign w_fire   = w_load && w_any;
    assign in_ready = w_gnt & {NUM_IN{w_load}};
    assign w_data   = in_data[int'(w_idx)*DATA_SIZE +: DATA_SIZE];

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (w_fire),
        .gnt     (w_gnt),
        .gnt_idx (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= w_data;
                r_src  <= w_idx;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

    a_rdy_onehot: assert property (
        @(posedge clk) $onehot0(in_ready)
    );
    a_hold: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src))
    );
endmodule
